// File: rtl/fx_ga_iocyc_if.sv
// ----------------------------------------------------------------------------
// fx_ga_iocyc_if
// Bundles the CPU-side access request and the device-side 16-bit bus used by
// the I/O cycle sequencer.
//   CPU side : start, rw, ben[3:0] (active-low), cpuDi[31:0] -> sequencer
//              cpuDo[31:0], readyn, busy, toErr           <- sequencer
//   Dev side : devA1, devBen[1:0], devDo[15:0], devRdn, devWrn <- sequencer
//              devDi[15:0], devBusyn                          -> sequencer
// Modports:
//   slave  - the sequencer itself
//   master - whatever drives the CPU request and models the devices
// ----------------------------------------------------------------------------
interface fx_ga_iocyc_if;
    logic        start;
    logic        rw;
    logic [3:0]  ben;
    logic [31:0] cpuDi;
    logic [31:0] cpuDo;
    logic        readyn;
    logic        busy;
    logic        toErr;
    logic        devA1;
    logic [1:0]  devBen;
    logic [15:0] devDo;
    logic [15:0] devDi;
    logic        devRdn;
    logic        devWrn;
    logic        devBusyn;

    modport slave (
        input  start, rw, ben, cpuDi, devDi, devBusyn,
        output cpuDo, readyn, busy, toErr, devA1, devBen, devDo, devRdn, devWrn
    );

    modport master (
        output start, rw, ben, cpuDi, devDi, devBusyn,
        input  cpuDo, readyn, busy, toErr, devA1, devBen, devDo, devRdn, devWrn
    );
endinterface

// File: rtl/fx_ga_iocyc.sv
// ----------------------------------------------------------------------------
// fx_ga_iocyc
// I/O cycle sequencer for the gate array's 16-bit device bus. One CPU access
// of up to 32 bits (byte-enabled) becomes one or two 16-bit device cycles,
// each made of SETUP -> STROBE -> HOLD, followed by a single DONE cycle in
// which READYn is low and CPU_DO carries the assembled read data.
// Ports:
//   i_clk  - system clock
//   i_res  - synchronous reset, active-high
//   i_ce   - clock enable; all state and outputs freeze while low
//   bus    - fx_ga_iocyc_if.slave: CPU request/response and device bus
// Parameters:
//   SETUP_CYC  - CE-cycles of address/data before the strobe (1..15)
//   STROBE_MIN - minimum strobe width in CE-cycles (1..15)
//   HOLD_CYC   - CE-cycles of address/data after the strobe (1..15)
//   TIMEOUT    - strobe width at which a stalled device is abandoned
// ----------------------------------------------------------------------------
module fx_ga_iocyc #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_MIN = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic          i_clk,
    input logic          i_res,
    input logic          i_ce,
    fx_ga_iocyc_if.slave bus
);

    localparam logic [7:0] L_SETUP   = 8'(SETUP_CYC);
    localparam logic [7:0] L_STRMIN  = 8'(STROBE_MIN);
    localparam logic [7:0] L_HOLD    = 8'(HOLD_CYC);
    localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_rw;
    logic [3:0]  r_ben;
    logic [31:0] r_cpuDi;
    logic [31:0] r_cpuDo;
    logic        r_half;
    logic        r_upperPend;
    logic        r_toErr;

    state_t      w_stateNext;
    logic [7:0]  w_cntNext;
    logic        w_accept;
    logic        w_needLower;
    logic        w_needUpper;
    logic        w_strobeExit;
    logic        w_timeout;
    logic        w_goUpper;
    logic        w_active;

    // Next-state logic. r_cnt is reused as the per-phase cycle counter; it is
    // reloaded with 1 on every phase entry so it always holds "cycles spent
    // in this phase including the current one", which makes it the strobe
    // width directly while in STROBE.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_accept     = 1'b0;
        w_strobeExit = 1'b0;
        w_timeout    = 1'b0;
        w_goUpper    = 1'b0;
        w_needLower  = (bus.ben[1:0] != 2'b11);
        w_needUpper  = (bus.ben[3:2] != 2'b11);

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept  = 1'b1;
                    w_cntNext = 8'd1;
                    // An access with no bytes enabled completes without
                    // touching the device bus.
                    w_stateNext = (w_needLower || w_needUpper) ? S_SETUP : S_DONE;
                end
            end
            S_SETUP: begin
                if (r_cnt >= L_SETUP) begin
                    w_stateNext = S_STROBE;
                    w_cntNext   = 8'd1;
                end else begin
                    w_cntNext = r_cnt + 8'd1;
                end
            end
            S_STROBE: begin
                // A ready device wins over the timeout when both hold on the
                // same cycle, so TIMEOUT == STROBE_MIN still completes cleanly.
                if ((r_cnt >= L_STRMIN) && bus.devBusyn) begin
                    w_strobeExit = 1'b1;
                end else if (r_cnt >= L_TIMEOUT) begin
                    w_strobeExit = 1'b1;
                    w_timeout    = 1'b1;
                end
                if (w_strobeExit) begin
                    w_stateNext = S_HOLD;
                    w_cntNext   = 8'd1;
                end else begin
                    w_cntNext = r_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt >= L_HOLD) begin
                    w_cntNext = 8'd1;
                    if (r_upperPend) begin
                        w_goUpper   = 1'b1;
                        w_stateNext = S_SETUP;
                    end else begin
                        w_stateNext = S_DONE;
                    end
                end else begin
                    w_cntNext = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State register and access datapath. Reset takes priority over CE so an
    // access can be killed even while the enable is low.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_rw        <= 1'b0;
            r_ben       <= 4'hF;
            r_cpuDi     <= 32'd0;
            r_cpuDo     <= 32'd0;
            r_half      <= 1'b0;
            r_upperPend <= 1'b0;
            r_toErr     <= 1'b0;
        end else if (i_ce) begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_toErr <= w_timeout;

            if (w_accept) begin
                r_rw        <= bus.rw;
                r_ben       <= bus.ben;
                r_cpuDi     <= bus.cpuDi;
                r_cpuDo     <= 32'd0;
                r_half      <= ~w_needLower;
                r_upperPend <= w_needLower & w_needUpper;
            end

            if (w_goUpper) begin
                r_half      <= 1'b1;
                r_upperPend <= 1'b0;
            end

            // Read data is captured on the strobe's exit edge; a device that
            // never released BUSYn returns all-ones for its half.
            if (w_strobeExit && r_rw) begin
                if (r_half) begin
                    r_cpuDo[31:16] <= w_timeout ? 16'hFFFF : bus.devDi;
                end else begin
                    r_cpuDo[15:0]  <= w_timeout ? 16'hFFFF : bus.devDi;
                end
            end
        end
    end

    // Address, byte enables and write data are only presented while a device
    // cycle is in progress; in IDLE and DONE the bus rests at its idle values.
    always_comb begin
        w_active = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
    end

    assign bus.devA1  = w_active & r_half;
    assign bus.devBen = !w_active ? 2'b11 : (r_half ? r_ben[3:2] : r_ben[1:0]);
    assign bus.devDo  = !w_active ? 16'd0 : (r_half ? r_cpuDi[31:16] : r_cpuDi[15:0]);
    assign bus.devRdn = !((r_state == S_STROBE) && r_rw);
    assign bus.devWrn = !((r_state == S_STROBE) && !r_rw);
    assign bus.readyn = (r_state != S_DONE);
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.toErr  = r_toErr;
    assign bus.cpuDo  = r_cpuDo;

endmodule

// File: doc/fx_ga_iocyc.md
Name: fx_ga_iocyc

Overview:
I/O cycle sequencer for the gate array's 16-bit device bus (PSG, VPU, VCE, VDC0/1, MMC, internal GA registers).
- Takes one CPU I/O access (up to 32 bits, byte-enabled) and runs one or two 16-bit device cycles.
- Generates RDn/WRn strobes with setup/hold timing, honours the device BUSYn wait handshake, and enforces a timeout.
- Returns READYn and assembled read data to the CPU.
- Sits between the address decoder and the device chip-selects/strobes.

Parameters:
SETUP_CYC, 1, CE-cycles address/data valid before strobe (1..15)
STROBE_MIN, 2, minimum strobe width in CE-cycles (1..15)
HOLD_CYC, 1, CE-cycles address/data held after strobe release (1..15)
TIMEOUT, 255, maximum strobe width in CE-cycles before abort (STROBE_MIN..255)

Ports:
CLK  in  1  system clock
RES  in  1  synchronous reset, active-high
CE  in  1  clock enable; all state advances only when CE=1
START  in  1  access request; sampled only in IDLE with CE=1
RW  in  1  1=read, 0=write; latched at START
BEn  in  4  active-low byte enables; latched at START
CPU_DI  in  32  write data; latched at START
CPU_DO  out  32  read data; valid while READYn=0
READYn  out  1  access complete, low for exactly one CE-cycle
DEV_A1  out  1  0=lower halfword cycle, 1=upper halfword cycle
DEV_BEn  out  2  byte enables for the current half
DEV_DO  out  16  write data for the current half
DEV_DI  in  16  device read data
DEV_RDn  out  1  read strobe, active-low
DEV_WRn  out  1  write strobe, active-low
DEV_BUSYn  in  1  device wait request, active-low
BUSY  out  1  1 whenever state is not IDLE
TO_ERR  out  1  one-CE-cycle pulse when a strobe is aborted by timeout

Behaviour:
Reset and idle outputs:
- On RES: state IDLE. Outputs: READYn=1, DEV_RDn=1, DEV_WRn=1, BUSY=0, TO_ERR=0, DEV_A1=0, DEV_BEn=11, DEV_DO=0, CPU_DO=0.
- RES mid-access aborts at the next edge; strobes deassert in that same edge.
- The same idle values hold in IDLE except CPU_DO, which keeps its last value.

Half selection (at START):
- Lower half is needed when BEn[1:0]!=11; upper half when BEn[3:2]!=11.
- If both are needed, run lower first, then upper.
- BEn=1111: go directly to DONE with no strobes; CPU_DO=0.

States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE -> SETUP when START=1 (and CE). Latch RW/BEn/CPU_DI and clear CPU_DO.
- SETUP:
  - DEV_A1, DEV_BEn and DEV_DO are driven for the current half (DEV_DO = CPU_DI[15:0] or [31:16]).
  - Strobes are high.
  - Stay SETUP_CYC cycles, then go to STROBE.
- STROBE:
  - DEV_RDn=0 for a read, DEV_WRn=0 for a write.
  - Width counter starts at 1.
  - Leave when width>=STROBE_MIN and DEV_BUSYn=1.
  - If width reaches TIMEOUT while DEV_BUSYn=0, leave anyway and pulse TO_ERR.
  - Read capture happens on the exit edge: CPU_DO half = DEV_DI, or 16'hFFFF on a timeout.
- HOLD:
  - Strobes are high; address, data and BEn are held.
  - Stay HOLD_CYC cycles.
  - Then go to SETUP for the upper half if it is still pending, otherwise to DONE.
- DONE: READYn=0 for one cycle, then IDLE. A START during DONE is ignored.

Rules and boundaries:
- DEV_BUSYn is ignored outside STROBE.
- The unaccessed half of CPU_DO reads 0.
- START while BUSY=1 is ignored.
- A timeout on the lower half still proceeds to the upper half.
- When CE=0, all outputs and counters freeze.

Latency with defaults and no waits (START sampled at cycle 0):
- Single half: SETUP at 1, STROBE at 2-3, HOLD at 4, READYn=0 at cycle 5.
- Both halves: READYn=0 at cycle 9.
- Each cycle DEV_BUSYn=0 during STROBE (beyond the minimum) adds 1.

Test Plan:
1. Reset behaviour: RES held 3 cycles mid-STROBE -> DEV_RDn/DEV_WRn=1 next edge, BUSY=0, READYn=1, TO_ERR=0.
2. 16-bit read: BEn=1100, RW=1, DEV_DI=0x1234, BUSYn=1 -> DEV_A1=0, DEV_RDn low cycles 2-3, READYn=0 cycle 5, CPU_DO=0x00001234.
3. 32-bit write: BEn=0000, CPU_DI=0xAABBCCDD -> WRn pulses at cycles 2-3 (DEV_A1=0, DEV_DO=0xCCDD) and 6-7 (DEV_A1=1, DEV_DO=0xAABB); READYn=0 cycle 9.
4. Wait states: upper-byte read BEn=0111, DEV_BUSYn=0 for cycles 2-6 -> DEV_A1=1, DEV_BEn=01, strobe spans cycles 2-7, READYn=0 cycle 9.
5. Timeout: TIMEOUT=8, DEV_BUSYn stuck 0, 32-bit read -> each strobe is 8 cycles, TO_ERR pulses twice, CPU_DO=0xFFFFFFFF, READYn=0 cycle 21.
6. CE gating and null access: CE toggling 1/0 during test 2 -> identical sequence stretched 2x. BEn=1111 -> no strobes, READYn=0 at cycle 1, CPU_DO=0.
